// File: rtl/io_sequence_monitor.sv
// io_sequence_monitor: walks a programmable table of masked pad-bus patterns in order under a cycle budget.
// Build option IO_SEQ_MON_HOLD_EN: a stage must match for 4 consecutive cycles before it advances.
module io_sequence_monitor #(
    parameter int WIDTH  = 38,
    parameter int STAGES = 4,
    parameter int TMO_W  = 18
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic [WIDTH-1:0] sample_i,
    input  logic             prog_we_i,
    input  logic [3:0]       prog_idx_i,
    input  logic [WIDTH-1:0] prog_mask_i,
    input  logic [WIDTH-1:0] prog_val_i,
    input  logic [TMO_W-1:0] tmo_limit_i,
    input  logic             start_i,
    input  logic             abort_i,
    output logic             busy_o,
    output logic             pass_o,
    output logic             fail_o,
    output logic             tmo_o,
    output logic [3:0]       stage_o,
    output logic [3:0]       fail_stage_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_PASS = 2'd2,
        ST_FAIL = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [3:0]       stage_q, stage_d;
    logic [3:0]       fstage_q, fstage_d;
    logic [TMO_W-1:0] cnt_q, cnt_d;
    logic             pass_q, pass_d;
    logic             fail_q, fail_d;
    logic             tmo_q, tmo_d;
    logic [WIDTH-1:0] mask_q [STAGES];
    logic [WIDTH-1:0] val_q  [STAGES];
    logic [WIDTH-1:0] cur_mask_s, cur_val_s;
    logic             match_s, advance_s, last_s;

`ifdef IO_SEQ_MON_HOLD_EN
    logic [1:0]       hold_q, hold_d;
`endif

    // Pattern table: writable only while no sequence is running
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            for (int k = 0; k < STAGES; k++) begin
                mask_q[k] <= {WIDTH{1'b0}};
                val_q[k]  <= {WIDTH{1'b0}};
            end
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (prog_we_i && (state_q != ST_RUN) && (prog_idx_i == 4'(k))) begin
                    mask_q[k] <= prog_mask_i;
                    val_q[k]  <= prog_val_i;
                end
            end
        end
    end

    // Select the active stage's pattern and evaluate the masked compare
    always_comb begin
        cur_mask_s = {WIDTH{1'b0}};
        cur_val_s  = {WIDTH{1'b0}};
        for (int k = 0; k < STAGES; k++) begin
            cur_mask_s = cur_mask_s | ({WIDTH{stage_q == 4'(k)}} & mask_q[k]);
            cur_val_s  = cur_val_s  | ({WIDTH{stage_q == 4'(k)}} & val_q[k]);
        end
        match_s = ((sample_i & cur_mask_s) == (cur_val_s & cur_mask_s));
        last_s  = (stage_q == 4'(STAGES - 1));
`ifdef IO_SEQ_MON_HOLD_EN
        advance_s = match_s && (hold_q == 2'd3);
`else
        advance_s = match_s;
`endif
    end

    // Sequencer next-state: abort beats match, match beats timeout
    always_comb begin
        state_d  = state_q;
        stage_d  = stage_q;
        fstage_d = fstage_q;
        cnt_d    = cnt_q;
        pass_d   = pass_q;
        fail_d   = fail_q;
        tmo_d    = tmo_q;
`ifdef IO_SEQ_MON_HOLD_EN
        hold_d   = hold_q;
`endif
        case (state_q)
            ST_RUN: begin
                cnt_d = (cnt_q == {TMO_W{1'b1}}) ? cnt_q : cnt_q + TMO_W'(1);
`ifdef IO_SEQ_MON_HOLD_EN
                hold_d = (match_s && !advance_s) ? hold_q + 2'd1 : 2'd0;
`endif
                if (abort_i) begin
                    state_d  = ST_FAIL;
                    fail_d   = 1'b1;
                    tmo_d    = 1'b0;
                    fstage_d = stage_q;
                end else if (advance_s) begin
                    // On STAGES=16 the final stage_o wraps to 0; pass_o carries the result
                    stage_d = stage_q + 4'd1;
                    if (last_s) begin
                        state_d = ST_PASS;
                        pass_d  = 1'b1;
                    end else begin
                        state_d = ST_RUN;
                    end
                end else if (cnt_q == tmo_limit_i) begin
                    state_d  = ST_FAIL;
                    fail_d   = 1'b1;
                    tmo_d    = 1'b1;
                    fstage_d = stage_q;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_IDLE, ST_PASS, ST_FAIL: begin
                if (start_i) begin
                    state_d  = ST_RUN;
                    stage_d  = 4'd0;
                    fstage_d = 4'd0;
                    cnt_d    = {TMO_W{1'b0}};
                    pass_d   = 1'b0;
                    fail_d   = 1'b0;
                    tmo_d    = 1'b0;
`ifdef IO_SEQ_MON_HOLD_EN
                    hold_d   = 2'd0;
`endif
                end else begin
                    state_d = state_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Sequencer state and status registers
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q  <= ST_IDLE;
            stage_q  <= 4'd0;
            fstage_q <= 4'd0;
            cnt_q    <= {TMO_W{1'b0}};
            pass_q   <= 1'b0;
            fail_q   <= 1'b0;
            tmo_q    <= 1'b0;
`ifdef IO_SEQ_MON_HOLD_EN
            hold_q   <= 2'd0;
`endif
        end else begin
            state_q  <= state_d;
            stage_q  <= stage_d;
            fstage_q <= fstage_d;
            cnt_q    <= cnt_d;
            pass_q   <= pass_d;
            fail_q   <= fail_d;
            tmo_q    <= tmo_d;
`ifdef IO_SEQ_MON_HOLD_EN
            hold_q   <= hold_d;
`endif
        end
    end

    assign busy_o       = (state_q == ST_RUN);
    assign pass_o       = pass_q;
    assign fail_o       = fail_q;
    assign tmo_o        = tmo_q;
    assign stage_o      = stage_q;
    assign fail_stage_o = fstage_q;

endmodule

// File: tb/tb_io_sequence_monitor.sv
// Self-checking bench for io_sequence_monitor: match-rule vector table, directed sequences, randomized run vs model.
module tb_io_sequence_monitor;

    localparam int W      = 38;
    localparam int STAGES = 4;
    localparam int TMO_W  = 18;
`ifdef IO_SEQ_MON_HOLD_EN
    localparam int HOLD = 4;
`else
    localparam int HOLD = 1;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic [W-1:0]     sample_i;
    logic             prog_we_i;
    logic [3:0]       prog_idx_i;
    logic [W-1:0]     prog_mask_i, prog_val_i;
    logic [TMO_W-1:0] tmo_limit_i;
    logic             start_i, abort_i;
    logic             busy_o, pass_o, fail_o, tmo_o;
    logic [3:0]       stage_o, fail_stage_o;

    int checks = 0;
    int errors = 0;

    io_sequence_monitor #(.WIDTH(W), .STAGES(STAGES), .TMO_W(TMO_W)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .sample_i(sample_i),
        .prog_we_i(prog_we_i), .prog_idx_i(prog_idx_i),
        .prog_mask_i(prog_mask_i), .prog_val_i(prog_val_i),
        .tmo_limit_i(tmo_limit_i), .start_i(start_i), .abort_i(abort_i),
        .busy_o(busy_o), .pass_o(pass_o), .fail_o(fail_o), .tmo_o(tmo_o),
        .stage_o(stage_o), .fail_stage_o(fail_stage_o)
    );

    always #5 clk = ~clk;

    // Reference model: stage index, elapsed RUN cycles, consecutive-match run length
    bit           m_run, m_pass, m_fail, m_tmo;
    int           m_stage, m_fstage, m_cnt, m_len;
    logic [W-1:0] m_mask [STAGES];
    logic [W-1:0] m_val  [STAGES];

    task automatic model_reset();
        m_run = 0; m_pass = 0; m_fail = 0; m_tmo = 0;
        m_stage = 0; m_fstage = 0; m_cnt = 0; m_len = 0;
        for (int k = 0; k < STAGES; k++) begin
            m_mask[k] = '0;
            m_val[k]  = '0;
        end
    endtask

    task automatic model_step();
        logic [W-1:0] mk, vl;
        if (m_run) begin
            if (abort_i) begin
                m_run = 0; m_fail = 1; m_tmo = 0; m_fstage = m_stage;
            end else begin
                mk = m_mask[m_stage];
                vl = m_val[m_stage];
                m_len = ((sample_i & mk) == (vl & mk)) ? m_len + 1 : 0;
                if (m_len == HOLD) begin
                    m_len = 0;
                    m_stage++;
                    if (m_stage == STAGES) begin
                        m_run = 0; m_pass = 1;
                    end
                end else if (m_cnt == int'(tmo_limit_i)) begin
                    m_run = 0; m_fail = 1; m_tmo = 1; m_fstage = m_stage;
                end
                m_cnt++;
            end
        end else begin
            if (prog_we_i && int'(prog_idx_i) < STAGES) begin
                m_mask[prog_idx_i] = prog_mask_i;
                m_val[prog_idx_i]  = prog_val_i;
            end
            if (start_i) begin
                m_run = 1; m_pass = 0; m_fail = 0; m_tmo = 0;
                m_stage = 0; m_cnt = 0; m_len = 0;
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_model();
        chk("busy", 32'(busy_o), 32'(m_run));
        chk("pass", 32'(pass_o), 32'(m_pass));
        chk("fail", 32'(fail_o), 32'(m_fail));
        chk("tmo", 32'(tmo_o), 32'(m_tmo));
        chk("stage", 32'(stage_o), 32'(m_stage));
        if (m_fail) chk("fail_stage", 32'(fail_stage_o), 32'(m_fstage));
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        compare_model();
    endtask

    task automatic idle_inputs();
        prog_we_i = 0; start_i = 0; abort_i = 0;
    endtask

    task automatic prog(input int idx, input logic [W-1:0] mk, input logic [W-1:0] vl);
        prog_we_i = 1; prog_idx_i = 4'(idx); prog_mask_i = mk; prog_val_i = vl;
        tick();
        prog_we_i = 0;
    endtask

    task automatic start_seq(input int limit);
        tmo_limit_i = TMO_W'(limit);
        start_i = 1;
        tick();
        start_i = 0;
    endtask

    task automatic do_reset();
        rst = 1;
        #2;
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_pass", 32'(pass_o), 32'd0);
        chk("rst_fail", 32'(fail_o), 32'd0);
        chk("rst_stage", 32'(stage_o), 32'd0);
        model_reset();
        @(posedge clk);
        #3;
        rst = 0;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [W-1:0] mask;
        logic [W-1:0] val;
        logic [W-1:0] smp;
        bit           match;
    } vec_t;

    vec_t vecs [8];
    logic [W-1:0] s_m0, s_v0, s_m1, s_v1, s_m2, s_v2, s_m3, s_v3;
    logic [W-1:0] p0, p1, p2, p3, mk;
    int first_fail;

    initial begin
        vecs[0] = '{38'h0,            38'h3F_FFFF_FFFF, 38'h0,            1'b1};
        vecs[1] = '{38'h1,            38'h1,            38'h1,            1'b1};
        vecs[2] = '{38'h1,            38'h1,            38'h0,            1'b0};
        vecs[3] = '{38'h30_0000_0000, 38'h20_0000_0000, 38'h20_0000_0000, 1'b1};
        vecs[4] = '{38'h30_0000_0000, 38'h20_0000_0000, 38'h30_0000_0000, 1'b0};
        vecs[5] = '{38'h3F_FFFF_FFFF, 38'h15_5555_5555, 38'h15_5555_5555, 1'b1};
        vecs[6] = '{38'h3F_FFFF_FFFF, 38'h15_5555_5555, 38'h35_5555_5555, 1'b0};
        vecs[7] = '{38'h0F_0000_00F0, 38'h3F_FFFF_FFFF, 38'h0F_0000_00F0, 1'b1};
        s_m0 = 38'h00_03F0_0000; s_v0 = 38'h0;
        s_m1 = 38'h30_0000_0000; s_v1 = 38'h20_0000_0000;
        s_m2 = 38'h0F_FFF0_0000; s_v2 = 38'h00_0010_0000;
        s_m3 = 38'h30_0000_0000; s_v3 = 38'h0;
        p0 = 38'h20_0000_0000;
        p1 = 38'h20_0000_0000;
        p2 = 38'h20_0010_0000;
        p3 = 38'h00_0010_0000;

        idle_inputs();
        sample_i = '0; prog_idx_i = '0; prog_mask_i = '0; prog_val_i = '0; tmo_limit_i = '0;
        do_reset();

        // Match-rule table on stage 0; limit HOLD-1 makes a non-match time out on the deciding cycle
        for (int i = 0; i < 8; i++) begin
            prog(0, vecs[i].mask, vecs[i].val);
            sample_i = vecs[i].smp;
            start_seq(HOLD - 1);
            for (int c = 0; c < HOLD; c++) tick();
            chk("vec_stage", 32'(stage_o), vecs[i].match ? 32'd1 : 32'd0);
            chk("vec_fail", 32'(fail_o), vecs[i].match ? 32'd0 : 32'd1);
            abort_i = 1; tick(); abort_i = 0;
        end

        // Out-of-range index must not alias onto stage 0; all-zero table passes in STAGES*HOLD cycles
        do_reset();
        prog(4, 38'h3F_FFFF_FFFF, 38'h3F_FFFF_FFFF);
        sample_i = '0;
        start_seq(1000);
        for (int c = 1; c <= STAGES * HOLD; c++) begin
            tick();
            if (c == STAGES * HOLD - 1) chk("allmatch_not_yet", 32'(pass_o), 32'd0);
        end
        chk("allmatch_pass", 32'(pass_o), 32'd1);
        chk("allmatch_stage", 32'(stage_o), 32'(STAGES));

        // LA-style flow, patterns driven in order
        prog(0, s_m0, s_v0); prog(1, s_m1, s_v1); prog(2, s_m2, s_v2); prog(3, s_m3, s_v3);
        start_seq(1000);
        sample_i = p0; for (int c = 0; c < HOLD; c++) tick();
        sample_i = p1; for (int c = 0; c < HOLD; c++) tick();
        sample_i = p2; for (int c = 0; c < HOLD; c++) tick();
        sample_i = p3; for (int c = 0; c < HOLD; c++) tick();
        chk("flow_pass", 32'(pass_o), 32'd1);
        chk("flow_stage", 32'(stage_o), 32'd4);
        chk("flow_busy", 32'(busy_o), 32'd0);

        // Stage 2 pattern never appears: timeout 51 cycles after start
        sample_i = p0;
        start_seq(50);
        first_fail = 0;
        for (int c = 1; c <= 60; c++) begin
            tick();
            if (fail_o && first_fail == 0) first_fail = c;
        end
        chk("tmo_latency", 32'(first_fail), 32'd51);
        chk("tmo_flag", 32'(tmo_o), 32'd1);
        chk("tmo_fstage", 32'(fail_stage_o), 32'd2);

        // Abort at stage 1, then re-arm clears flags
        sample_i = p0;
        start_seq(1000);
        for (int c = 0; c < HOLD; c++) tick();
        sample_i = '0;
        tick();
        chk("abort_pre_stage", 32'(stage_o), 32'd1);
        abort_i = 1; start_i = 1; tick(); abort_i = 0; start_i = 0;
        chk("abort_fail", 32'(fail_o), 32'd1);
        chk("abort_tmo", 32'(tmo_o), 32'd0);
        chk("abort_fstage", 32'(fail_stage_o), 32'd1);
        start_seq(1000);
        chk("rearm_busy", 32'(busy_o), 32'd1);
        chk("rearm_fail", 32'(fail_o), 32'd0);
        chk("rearm_stage", 32'(stage_o), 32'd0);

        // Async reset mid-run, then the cleared table passes immediately
        #2;
        do_reset();
        chk("rst_fail_after", 32'(fail_o), 32'd0);
        sample_i = 38'h2A_AAAA_5555;
        start_seq(1000);
        for (int c = 0; c < STAGES * HOLD; c++) tick();
        chk("rst_table_cleared", 32'(pass_o), 32'd1);

`ifdef IO_SEQ_MON_HOLD_EN
        prog(0, 38'h1, 38'h1);
        sample_i = '0;
        start_seq(1000);
        sample_i = 38'h1; for (int c = 0; c < 3; c++) tick();
        sample_i = 38'h0; tick();
        chk("glitch3_stage", 32'(stage_o), 32'd0);
        sample_i = 38'h1; for (int c = 0; c < 4; c++) tick();
        chk("hold4_stage", 32'(stage_o), 32'd1);
        abort_i = 1; tick(); abort_i = 0;
`endif

        // Randomized run against the model
        for (int c = 0; c < 4000; c++) begin
            start_i   = ($urandom_range(0, 9) == 0);
            abort_i   = ($urandom_range(0, 39) == 0);
            prog_we_i = ($urandom_range(0, 3) == 0);
            prog_idx_i = 4'($urandom_range(0, 5));
            mk = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
            prog_mask_i = ($urandom_range(0, 4) == 0) ? '0 : mk;
            prog_val_i  = {$urandom, $urandom};
            if (start_i) tmo_limit_i = TMO_W'($urandom_range(0, 24));
            if (m_run && $urandom_range(0, 2) != 0)
                sample_i = (m_val[m_stage] & m_mask[m_stage]) | ({$urandom, $urandom} & ~m_mask[m_stage]);
            else
                sample_i = {$urandom, $urandom};
            tick();
        end
        idle_inputs();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
